// File: rtl/cofre_pkg.sv
// rtl/cofre_pkg.sv - shared types and constants for the safe controller
package cofre_pkg;

    localparam int W_SENHA = 4;

    localparam int                   MAX_TENT_DEF  = 3;
    localparam int                   T_ABERTO_DEF  = 50_000_000;
    localparam int                   T_BLOQ_DEF    = 250_000_000;
    localparam logic [W_SENHA-1:0]   SENHA_INI_DEF = 4'd0;

    typedef enum logic [2:0] {
        OCIOSO,
        VERIFICA,
        ABERTO,
        ERRO,
        BLOQUEADO
    } estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cofre_temporizador.sv
// rtl/cofre_temporizador.sv - saturating up-counter with clear and terminal count
module cofre_temporizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] ultimo,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count while enabled; hold at the terminal value so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != ultimo)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == ultimo);

endmodule

// File: rtl/cofre_controle.sv
// rtl/cofre_controle.sv - safe controller: password, attempts, open/lockout sequencing
module cofre_controle
    import cofre_pkg::*;
#(
    parameter int                 MAX_TENT  = MAX_TENT_DEF,
    parameter int                 T_ABERTO  = T_ABERTO_DEF,
    parameter int                 T_BLOQ    = T_BLOQ_DEF,
    parameter logic [W_SENHA-1:0] SENHA_INI = SENHA_INI_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               confirma,
    input  logic               programa,
    input  logic [W_SENHA-1:0] tentativa_in,
    input  logic               igual,
    input  logic               ate3,
    input  logic               errada,
    output logic [W_SENHA-1:0] senha,
    output logic [W_SENHA-1:0] tentativa,
    output logic               aberto,
    output logic               dica,
    output logic               erro,
    output logic               bloqueado,
    output logic [2:0]         erros
);

    localparam int               T_MAX      = max_int(T_ABERTO, T_BLOQ);
    localparam int               W_T        = $clog2(T_MAX);
    localparam logic [W_T-1:0]   ULT_ABERTO = W_T'(T_ABERTO - 1);
    localparam logic [W_T-1:0]   ULT_BLOQ   = W_T'(T_BLOQ - 1);
    localparam logic [2:0]       MAX_TENT_L = 3'(MAX_TENT);

    estado_t            estado_q, estado_d;
    logic [W_SENHA-1:0] senha_q, senha_d;
    logic [W_SENHA-1:0] tentativa_q, tentativa_d;
    logic               aberto_q, aberto_d;
    logic               dica_q, dica_d;
    logic               erro_q, erro_d;
    logic               bloqueado_q, bloqueado_d;
    logic [2:0]         erros_q, erros_d;
    logic [2:0]         erros_inc;

    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_tc;
    logic [W_T-1:0]     tmr_ult;

    // One timer serves both timeouts; it is cleared in VERIFICA, just before either is entered.
    assign tmr_clr = (estado_q == VERIFICA);
    assign tmr_en  = (estado_q == ABERTO) || (estado_q == BLOQUEADO);
    assign tmr_ult = (estado_q == BLOQUEADO) ? ULT_BLOQ : ULT_ABERTO;

    cofre_temporizador #(
        .W (W_T)
    ) u_temporizador (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .ultimo (tmr_ult),
        .tc     (tmr_tc)
    );

    // erros stays below MAX_TENT outside lockout, so this cannot overflow 3 bits.
    assign erros_inc = erros_q + 3'd1;

    // Next-state and next-output logic; every output is a register.
    always_comb begin
        estado_d    = estado_q;
        senha_d     = senha_q;
        tentativa_d = tentativa_q;
        aberto_d    = aberto_q;
        dica_d      = dica_q;
        erro_d      = erro_q;
        bloqueado_d = bloqueado_q;
        erros_d     = erros_q;
        case (estado_q)
            OCIOSO, ERRO: begin
                if (confirma) begin
                    tentativa_d = tentativa_in;
                    estado_d    = VERIFICA;
                end
            end
            VERIFICA: begin
                if (igual) begin
                    estado_d = ABERTO;
                    aberto_d = 1'b1;
                    erros_d  = 3'd0;
                    erro_d   = 1'b0;
                    dica_d   = 1'b0;
                end else if (errada) begin
                    erro_d = 1'b1;
                    if (erros_inc == MAX_TENT_L) begin
                        estado_d    = BLOQUEADO;
                        bloqueado_d = 1'b1;
                        erros_d     = MAX_TENT_L;
                        dica_d      = 1'b0;
                    end else begin
                        estado_d = ERRO;
                        erros_d  = erros_inc;
                        dica_d   = ate3;
                    end
                end else begin
                    estado_d = OCIOSO;
                end
            end
            ABERTO: begin
                // confirma wins over expiry so a password write is never dropped.
                if (confirma) begin
                    if (programa) begin
                        senha_d = tentativa_in;
                    end
                    estado_d = OCIOSO;
                    aberto_d = 1'b0;
                end else if (tmr_tc) begin
                    estado_d = OCIOSO;
                    aberto_d = 1'b0;
                end
            end
            BLOQUEADO: begin
                if (tmr_tc) begin
                    estado_d    = OCIOSO;
                    bloqueado_d = 1'b0;
                    erros_d     = 3'd0;
                    erro_d      = 1'b0;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            senha_q     <= SENHA_INI;
            tentativa_q <= '0;
            aberto_q    <= 1'b0;
            dica_q      <= 1'b0;
            erro_q      <= 1'b0;
            bloqueado_q <= 1'b0;
            erros_q     <= 3'd0;
        end else begin
            estado_q    <= estado_d;
            senha_q     <= senha_d;
            tentativa_q <= tentativa_d;
            aberto_q    <= aberto_d;
            dica_q      <= dica_d;
            erro_q      <= erro_d;
            bloqueado_q <= bloqueado_d;
            erros_q     <= erros_d;
        end
    end

    assign senha     = senha_q;
    assign tentativa = tentativa_q;
    assign aberto    = aberto_q;
    assign dica      = dica_q;
    assign erro      = erro_q;
    assign bloqueado = bloqueado_q;
    assign erros     = erros_q;

endmodule

// File: tb/tb_cofre_controle.sv
// tb/tb_cofre_controle.sv - self-checking bench for cofre_controle
module tb_cofre_controle;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       confirma;
    logic       programa;
    logic [3:0] tentativa_in;
    logic       igual;
    logic       ate3;
    logic       errada;
    logic [3:0] senha;
    logic [3:0] tentativa;
    logic       aberto;
    logic       dica;
    logic       erro;
    logic       bloqueado;
    logic [2:0] erros;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external subtract/compare datapath.
    logic [3:0] dif;
    assign dif    = (senha > tentativa) ? (senha - tentativa) : (tentativa - senha);
    assign igual  = (senha == tentativa);
    assign errada = !igual;
    assign ate3   = !igual && (dif <= 4'd3);

    cofre_controle #(
        .MAX_TENT  (3),
        .T_ABERTO  (8),
        .T_BLOQ    (12),
        .SENHA_INI (4'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .confirma     (confirma),
        .programa     (programa),
        .tentativa_in (tentativa_in),
        .igual        (igual),
        .ate3         (ate3),
        .errada       (errada),
        .senha        (senha),
        .tentativa    (tentativa),
        .aberto       (aberto),
        .dica         (dica),
        .erro         (erro),
        .bloqueado    (bloqueado),
        .erros        (erros)
    );

    typedef struct {
        logic       ab;
        logic       di;
        logic       er;
        logic       bl;
        logic [2:0] ers;
        logic [3:0] ten;
    } exp_t;

    typedef struct {
        logic [3:0] tent;
        logic       prog;
        logic [3:0] novo;
        logic       ab;
        logic       di;
        logic       er;
        logic       bl;
        logic [2:0] ers;
        logic [3:0] sen;
    } vec_t;

    exp_t sb[$];
    vec_t tab[9];

    task automatic chk(input string nome, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nome, act, exp);
        end
    endtask

    // Submit one attempt; the expected verdict is queued and checked two edges later.
    task automatic tentar(input logic [3:0] v, input logic ab, input logic di,
                          input logic er, input logic bl, input logic [2:0] ers);
        exp_t e;
        exp_t g;
        e = '{ab, di, er, bl, ers, v};
        sb.push_back(e);
        @(negedge clk);
        confirma     = 1'b1;
        tentativa_in = v;
        @(negedge clk);
        confirma = 1'b0;
        @(negedge clk);
        g = sb.pop_front();
        chk("aberto",    aberto,    g.ab);
        chk("dica",      dica,      g.di);
        chk("erro",      erro,      g.er);
        chk("bloqueado", bloqueado, g.bl);
        chk("erros",     erros,     g.ers);
        chk("tentativa", tentativa, g.ten);
    endtask

    task automatic fechar(input logic prog, input logic [3:0] novo);
        @(negedge clk);
        confirma     = 1'b1;
        programa     = prog;
        tentativa_in = novo;
        @(negedge clk);
        confirma = 1'b0;
        programa = 1'b0;
        chk("fechado", aberto, 0);
    endtask

    initial begin
        int n;
        tab[0] = '{4'd0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd9};
        tab[1] = '{4'd9, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd9};
        tab[2] = '{4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd9};
        tab[3] = '{4'd9, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd9};
        tab[4] = '{4'd7, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'd9};
        tab[5] = '{4'd9, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd9};
        tab[6] = '{4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd9};
        tab[7] = '{4'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 4'd9};
        tab[8] = '{4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 4'd9};

        rst_n        = 1'b0;
        confirma     = 1'b0;
        programa     = 1'b0;
        tentativa_in = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst aberto",    aberto,    0);
        chk("rst dica",      dica,      0);
        chk("rst erro",      erro,      0);
        chk("rst bloqueado", bloqueado, 0);
        chk("rst erros",     erros,     0);
        chk("rst senha",     senha,     0);
        chk("rst tentativa", tentativa, 0);
        rst_n = 1'b1;

        // Open with the reset password and let it auto-close.
        tentar(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (aberto) n++;
            else break;
        end
        chk("aberto ciclos", n, 8);

        for (int i = 0; i < 9; i++) begin
            tentar(tab[i].tent, tab[i].ab, tab[i].di, tab[i].er, tab[i].bl, tab[i].ers);
            if (tab[i].ab) fechar(tab[i].prog, tab[i].novo);
            chk("senha tab", senha, tab[i].sen);
        end

        // Lockout: confirma/programa ignored, bloqueado lasts exactly 12 cycles.
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            confirma     = (k == 0);
            programa     = (k == 0);
            tentativa_in = 4'd9;
            if (bloqueado) n++;
            else break;
        end
        confirma = 1'b0;
        programa = 1'b0;
        chk("bloq ciclos",    n,         12);
        chk("pos bloq erros", erros,     0);
        chk("pos bloq erro",  erro,      0);
        chk("pos bloq abre",  aberto,    0);
        chk("pos bloq senha", senha,     9);
        chk("pos bloq tent",  tentativa, 3);

        // confirma held into VERIFICA must not relatch the attempt.
        @(negedge clk);
        confirma     = 1'b1;
        tentativa_in = 4'd1;
        @(negedge clk);
        tentativa_in = 4'd9;
        @(negedge clk);
        confirma = 1'b0;
        chk("verif tent",  tentativa, 1);
        chk("verif erros", erros,     1);
        chk("verif erro",  erro,      1);

        // programa without ABERTO changes nothing.
        programa     = 1'b1;
        tentativa_in = 4'd5;
        repeat (3) @(negedge clk);
        programa = 1'b0;
        chk("prog fora senha", senha,  9);
        chk("prog fora erros", erros,  1);
        chk("prog fora abre",  aberto, 0);

        // confirma on the expiry cycle still writes the password.
        tentar(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        repeat (7) @(negedge clk);
        chk("ultimo ciclo aberto", aberto, 1);
        confirma     = 1'b1;
        programa     = 1'b1;
        tentativa_in = 4'd4;
        @(negedge clk);
        confirma = 1'b0;
        programa = 1'b0;
        chk("expira abre",  aberto, 0);
        chk("expira senha", senha,  4);

        // Asynchronous reset while open.
        tentar(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async aberto", aberto,    0);
        chk("async senha",  senha,     0);
        chk("async tent",   tentativa, 0);
        chk("async erros",  erros,     0);
        @(negedge clk);
        rst_n = 1'b1;
        tentar(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cofre_controle.md
# cofre_controle

Sequential controller for the 4-bit safe. It owns the stored password register and latches each user attempt. It feeds both values to the existing subtract/compare datapath and consumes that datapath's combinational verdict (equal / within 3 / wrong). From the verdict it sequences the safe through open, wrong-attempt, lockout and reprogramming behaviour. It sits between the user inputs (switches, confirm button) and the LEDs/display of the top level.

## Interface
Parameters:
- MAX_TENT, 3: consecutive wrong attempts that trigger lockout (range 1..7).
- T_ABERTO, 50_000_000: cycles the safe stays open before auto-close (≥2).
- T_BLOQ, 250_000_000: lockout duration in cycles (≥2).
- SENHA_INI, 4'd0: stored password after reset.

Ports:
- clk, in, 1: single system clock, all state on rising edge.
- rst_n, in, 1: asynchronous, active-low reset; deassertion synchronous to clk.
- confirma, in, 1: one-cycle pulse from the debounced button; submits an attempt or acts in ABERTO.
- programa, in, 1: level; with confirma in ABERTO, stores a new password.
- tentativa_in, in, 4: user switches.
- igual, in, 1: datapath verdict, senha == tentativa.
- ate3, in, 1: datapath verdict, |senha − tentativa| ≤ 3 and not equal.
- errada, in, 1: datapath verdict, not equal.
- senha, out, 4: stored password, drives datapath operand A.
- tentativa, out, 4: latched attempt, drives datapath operand B.
- aberto, out, 1: safe open (led0).
- dica, out, 1: last wrong attempt was within 3 (led1).
- erro, out, 1: last attempt wrong (led2).
- bloqueado, out, 1: lockout active.
- erros, out, 3: consecutive wrong-attempt count.

## Operation
- States: OCIOSO, VERIFICA, ABERTO, ERRO, BLOQUEADO.
- Reset values:
  - state OCIOSO, senha=SENHA_INI, tentativa=0, erros=0.
  - aberto, dica, erro and bloqueado all 0; timer=0.
- OCIOSO or ERRO, confirma=1:
  - tentativa ← tentativa_in.
  - go to VERIFICA.
  - erro and dica are kept until the VERIFICA result.
- VERIFICA (exactly one cycle):
  - The verdict inputs are sampled here; they are valid because the datapath is combinational on registered senha/tentativa.
  - igual=1: go to ABERTO; erros←0, erro←0, dica←0, timer←0.
  - errada=1 and erros+1 < MAX_TENT: go to ERRO; erros←erros+1, erro←1, dica←ate3.
  - errada=1 and erros+1 == MAX_TENT: go to BLOQUEADO; erros←MAX_TENT, erro←1, dica←0, timer←0.
  - If igual and errada are both 1 (illegal datapath output), igual has priority.
- ABERTO: aberto=1; timer increments each cycle.
  - confirma=1 and programa=1: senha ← tentativa_in; go to OCIOSO.
  - confirma=1 and programa=0: go to OCIOSO (manual close).
  - timer == T_ABERTO−1 with no confirma: go to OCIOSO.
  - confirma on the expiry cycle takes priority, so a password write is never lost.
- BLOQUEADO: bloqueado=1; confirma and programa are ignored; timer increments.
  - At timer == T_BLOQ−1: go to OCIOSO; erros←0, erro←0.
- confirma in VERIFICA is ignored.
- programa outside ABERTO is ignored.
- Timer width is sized for max(T_ABERTO, T_BLOQ); the timer never wraps.
- Reset asserted mid-operation (any state) returns all registers to reset values immediately, including senha←SENHA_INI.

## Timing
- confirma high at edge n: tentativa is updated at edge n, state is VERIFICA during cycle n→n+1, and the outputs reflect the verdict after edge n+1. Latency is 2 edges from the button pulse to the LED.
- aberto is high for exactly T_ABERTO cycles if no confirma arrives.
- bloqueado is high for exactly T_BLOQ cycles.
- The password write in ABERTO takes effect at the same edge as the ABERTO→OCIOSO transition.
- All outputs are registered; no combinational path from the inputs to the outputs.

## Structure
- Shared package cofre_pkg:
  - state enum (OCIOSO, VERIFICA, ABERTO, ERRO, BLOQUEADO).
  - width constant W_SENHA=4.
  - default parameter constants.
- One natural sub-module, cofre_temporizador: loadable up-counter with clear and terminal-count output for period N. It is used for both the ABERTO and BLOQUEADO timeouts.
- The top level instantiates cofre_controle alongside the existing subtractor, comparator and display.
- The datapath is unmodified.

## Test plan
Run with T_ABERTO=8, T_BLOQ=12.
- Reset, then confirma with tentativa_in=0 → after 2 edges aberto=1, erros=0; aberto falls after 8 cycles; state OCIOSO.
- In ABERTO, programa=1, confirma with tentativa_in=9 → senha=9. Then attempt 9 → aberto=1. Attempt 0 → erro=1, dica=0.
- senha=9, attempt 7 → erro=1, dica=1, erros=1. Then attempt 9 → aberto=1, erros=0, erro=0, dica=0.
- senha=9, three wrong attempts (1, 2, 3) → erros counts 1 then 2, then bloqueado=1. confirma with 9 during lockout is ignored. After 12 cycles bloqueado=0, erros=0, erro=0.
- confirma pulses during VERIFICA and programa asserted in OCIOSO → no state or senha change.
- rst_n asserted during ABERTO after senha=9 → outputs 0 asynchronously, senha=0. A post-reset attempt of 0 opens the safe.
